// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: picks 0..2 queue-head instructions per cycle, enforcing pairing, load-use and delay-slot rules.
// Optional ISSUE_PERF_CNT_EN adds wrapping dual/single/bubble issue counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_NORMAL  | dual issue allowed; a lone branch waits for its delay slot
// ST_DS_PEND | branch issued without its delay slot; next slot0 issue is the delay slot
module issue_ctrl #(
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       exception_flush,
    input  logic       stall,
    input  logic       q_valid0,
    input  logic       q_valid1,
    input  logic [2:0] q_class0,
    input  logic [2:0] q_class1,
    input  logic [4:0] q_rs0,
    input  logic [4:0] q_rt0,
    input  logic [4:0] q_rs1,
    input  logic [4:0] q_rt1,
    input  logic       q_rs_used0,
    input  logic       q_rt_used0,
    input  logic       q_rs_used1,
    input  logic       q_rt_used1,
    input  logic       q_w_ena0,
    input  logic       q_w_ena1,
    input  logic [4:0] q_w_dst0,
    input  logic [4:0] q_w_dst1,
    output logic       issue_valid0,
    output logic       issue_valid1,
    output logic       issue_ds0,
    output logic       issue_ds1,
    output logic [1:0] q_pop,
    output logic       ds_pending
`ifdef ISSUE_PERF_CNT_EN
   ,output logic [31:0] perf_dual,
    output logic [31:0] perf_single,
    output logic [31:0] perf_bubble
`endif
);

    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_MULDIV = 3'd4;
    localparam logic [2:0] CLS_PRIV   = 3'd5;
    localparam logic [1:0] LD_CNT_INIT = 2'(LOAD_USE_BUBBLES);

    typedef enum logic {ST_NORMAL, ST_DS_PEND} state_t;

    state_t     state, state_nxt;
    logic [4:0] ld_dst;
    logic [1:0] ld_cnt;
    logic       kill, block;
    logic       haz0, haz1, raw01, pair_ok, iss0, iss1;
    logic       mem0, mem1;

    function automatic logic reads(input logic rs_used, input logic [4:0] rs,
                                   input logic rt_used, input logic [4:0] rt,
                                   input logic [4:0] r);
        return (rs_used && rs == r) || (rt_used && rt == r);
    endfunction

    assign kill  = flush | exception_flush;
    assign block = rst | kill | stall;
    assign mem0  = (q_class0 == CLS_LOAD) || (q_class0 == CLS_STORE);
    assign mem1  = (q_class1 == CLS_LOAD) || (q_class1 == CLS_STORE);

    always_ff @(posedge clk) begin
        if (rst || kill)
            state <= ST_NORMAL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            ld_dst <= 5'd0;
            ld_cnt <= 2'd0;
        end else if (!stall) begin
            // Slot1 is younger, so its load shadows a slot0 load.
            if (iss1 && q_class1 == CLS_LOAD && q_w_ena1 && q_w_dst1 != 5'd0) begin
                ld_dst <= q_w_dst1;
                ld_cnt <= LD_CNT_INIT;
            end else if (iss0 && q_class0 == CLS_LOAD && q_w_ena0 && q_w_dst0 != 5'd0) begin
                ld_dst <= q_w_dst0;
                ld_cnt <= LD_CNT_INIT;
            end else if (ld_cnt != 2'd0) begin
                ld_cnt <= ld_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_NORMAL: begin
                if ((iss0 && q_class0 == CLS_BRANCH && !iss1) || (iss1 && q_class1 == CLS_BRANCH))
                    state_nxt = ST_DS_PEND;
            end
            ST_DS_PEND: begin
                if (iss0)
                    state_nxt = ST_NORMAL;
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    always_comb begin
        haz0  = (ld_cnt != 2'd0) && reads(q_rs_used0, q_rs0, q_rt_used0, q_rt0, ld_dst);
        haz1  = (ld_cnt != 2'd0) && reads(q_rs_used1, q_rs1, q_rt_used1, q_rt1, ld_dst);
        raw01 = q_w_ena0 && (q_w_dst0 != 5'd0) &&
                reads(q_rs_used1, q_rs1, q_rt_used1, q_rt1, q_w_dst0);
        pair_ok = q_valid1 && !haz1 && !raw01 && !(mem0 && mem1) &&
                  !(q_class0 == CLS_MULDIV && q_class1 == CLS_MULDIV) &&
                  (q_class0 != CLS_PRIV) && (q_class1 != CLS_PRIV) &&
                  (state == ST_NORMAL);
        // A branch in NORMAL holds until its delay slot is visible behind it.
        iss0 = !block && q_valid0 && !haz0 &&
               !(state == ST_NORMAL && q_class0 == CLS_BRANCH && !q_valid1);
        iss1 = iss0 && pair_ok;

        issue_valid0 = iss0;
        issue_valid1 = iss1;
        issue_ds0    = iss0 && (state == ST_DS_PEND);
        issue_ds1    = iss1 && (q_class0 == CLS_BRANCH);
        q_pop        = {1'b0, iss0} + {1'b0, iss1};
        ds_pending   = !block && (state == ST_DS_PEND);
    end

`ifdef ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual   <= 32'd0;
            perf_single <= 32'd0;
            perf_bubble <= 32'd0;
        end else begin
            if (q_pop == 2'd2)
                perf_dual <= perf_dual + 32'd1;
            if (q_pop == 2'd1)
                perf_single <= perf_single + 32'd1;
            if (q_valid0 && q_pop == 2'd0 && !stall)
                perf_bubble <= perf_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Dual-issue scheduler between the instruction queue and the two id1→id2 issue registers. Each cycle it picks 0, 1 or 2 head-of-queue instructions to issue and drives the queue pop count and per-slot valid. It also drives the delay-slot flag. It enforces pairing rules, load-use bubbles and branch/delay-slot ordering through a small FSM.

Parameters:
LOAD_USE_BUBBLES, 1, cycles after a load issues during which consumers of its destination are held (1..3)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  branch-mispredict flush
exception_flush  in  1  exception flush, highest priority after rst
stall  in  1  back-end stall; freezes issue
q_valid0 / q_valid1  in  1 each  queue head entry 0 / entry 1 present
q_class0 / q_class1  in  3 each  class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 MULDIV, 5 PRIV
q_rs0, q_rt0, q_rs1, q_rt1  in  5 each  source register numbers
q_rs_used0, q_rt_used0, q_rs_used1, q_rt_used1  in  1 each  source actually read
q_w_ena0 / q_w_ena1  in  1 each  writes a GPR
q_w_dst0 / q_w_dst1  in  5 each  destination GPR
issue_valid0  out  1  slot0 issue-register valid input
issue_valid1  out  1  slot1 issue-register valid input
issue_ds0  out  1  slot0 instruction is a delay slot
issue_ds1  out  1  slot1 instruction is a delay slot
q_pop  out  2  entries popped this cycle (0..2)
ds_pending  out  1  FSM in DS_PEND (debug/observe)

Behaviour:
- Issue outputs are combinational from inputs and state. State is registered. Zero added latency.
- rst high: all outputs 0, FSM=NORMAL, load tracker cleared, bubble counter=0.
- exception_flush or flush, stall ignored: outputs 0 that cycle, FSM→NORMAL, load tracker cleared. The front end redelivers any killed delay slot.
- stall (no flush): outputs 0, no pop, all state held.
- Load tracker: ld_dst (5b), ld_cnt (2b). A LOAD issued in either slot with w_ena and dst≠0 loads ld_dst and sets ld_cnt=LOAD_USE_BUBBLES. If both slots issue loads, slot1 wins. Otherwise ld_cnt decrements when >0 and not stalled.
- hazLU(x): ld_cnt>0 and a used source of entry x equals ld_dst.
- Slot0 issues if q_valid0 and !hazLU(0). Exception: in NORMAL a BRANCH in slot0 with q_valid1=0 waits (no issue).
- Slot1 issues only if slot0 issues, q_valid1, !hazLU(1), and all of these hold:
  - no RAW: not (q_w_ena0, q_w_dst0≠0, and a used source of entry1 equals q_w_dst0)
  - not both LOAD/STORE
  - not both MULDIV
  - neither is PRIV
  - FSM=NORMAL
- q_pop = issue_valid0 + issue_valid1.
- FSM NORMAL:
  - slot0 BRANCH issues with slot1 → issue_ds1=1, stay NORMAL.
  - slot0 BRANCH issues alone (slot1 blocked) → DS_PEND.
  - slot1 BRANCH issues → DS_PEND.
- FSM DS_PEND: single issue only. When slot0 issues, issue_ds0=1 and FSM→NORMAL. If slot0 cannot issue (queue empty or load-use), wait and hold DS_PEND.
- issue_ds0/issue_ds1 are 0 whenever the corresponding valid is 0.

Optional Feature:
ISSUE_PERF_CNT_EN.
- Defined: add outputs perf_dual, perf_single, perf_bubble (32 bits each, wrapping). They increment on cycles with q_pop=2, q_pop=1, and q_valid0 && q_pop=0 && !stall respectively. Cleared only by rst.
- Undefined: the ports and logic do not exist.

Test Plan:
- Two independent ALU ops, q_valid0=q_valid1=1 → issue_valid0=1, issue_valid1=1, q_pop=2.
- Entry0 writes r5, entry1 reads rs=r5 → slot0 only, q_pop=1. Same pair with dst=r0 → q_pop=2.
- LOAD to r8 issued alone, next cycle entry0 reads r8 with LOAD_USE_BUBBLES=1 → q_pop=0 for one cycle, then issue. With LOAD_USE_BUBBLES=2 → two stall cycles.
- BRANCH at entry0, q_valid1=0 → q_pop=0. Delay slot arrives → q_pop=2, issue_ds1=1. BRANCH at entry1 of an ALU pair → q_pop=2, ds_pending=1. Next cycle → q_pop=1, issue_ds0=1, ds_pending=0.
- ds_pending=1 with flush pulse → outputs 0 that cycle, ds_pending=0 next. stall held 3 cycles → q_pop=0 and ld_cnt frozen.
- Two LOADs, or a PRIV in either entry → q_pop=1 per cycle. With ISSUE_PERF_CNT_EN after 4 such cycles → perf_single=4.
